// File: rtl/intack_master_pkg.sv
// Shared types and constants for the interrupt-acknowledge master.
package KF8259_Common_Package;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_HOLD    = 2'd3
    } intack_state_e;

    localparam logic [7:0] CALL_OPCODE  = 8'hCD;
    localparam int         PULSES_8086  = 2;
    localparam int         PULSES_MCS80 = 3;

    function automatic logic [1:0] last_pulse(input logic is_8086);
        return is_8086 ? 2'(PULSES_8086 - 1) : 2'(PULSES_MCS80 - 1);
    endfunction

endpackage

// File: rtl/intack_master_phase_timer.sv
// Loadable phase down-counter; tc is high while the count sits at zero.
module intack_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_value;
        else if (count_q != '0)
            count_d = count_q - WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/intack_master.sv
// INTA sequencer for 8086 (2 pulses) and MCS-80 (3 pulses) acknowledge cycles.
// Define INTACK_OPCODE_CHECK_EN to check the MCS-80 CALL opcode on the first pulse.
//
// state   | meaning
// IDLE    | waiting for enable & interrupt
// ASSERT  | INTA low; bus captured on the last low clock
// RELEASE | INTA high gap between pulses
// HOLD    | vector_valid held until vector_ready
module intack_master
    import KF8259_Common_Package::*;
#(
    parameter int INTA_LOW_CYCLES  = 4,
    parameter int INTA_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        enable,
    input  logic        mode_8086,
    input  logic [7:0]  data_bus_in,
    input  logic        vector_ready,
    output logic        interrupt_acknowledge_n,
    output logic        busy,
    output logic        vector_valid,
    output logic [7:0]  vector,
    output logic [15:0] call_address,
    output logic        protocol_error
);

    localparam int MAX_CYC = (INTA_LOW_CYCLES > INTA_HIGH_CYCLES) ? INTA_LOW_CYCLES : INTA_HIGH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(INTA_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(INTA_HIGH_CYCLES - 1);

    intack_state_e state_q, state_d;
    logic          inta_n_q, inta_n_d;
    logic          mode_q, mode_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    byte1_q, byte1_d;
    logic [7:0]    byte2_q, byte2_d;
    logic          valid_q, valid_d;
    logic [7:0]    vector_q, vector_d;
    logic [15:0]   ca_q, ca_d;
    logic          perr_q, perr_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_tc;

    intack_phase_timer #(.WIDTH(CNT_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        inta_n_d    = inta_n_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        byte1_d     = byte1_q;
        byte2_d     = byte2_q;
        valid_d     = valid_q;
        vector_d    = vector_q;
        ca_d        = ca_q;
        perr_d      = perr_q;
        timer_load  = 1'b0;
        timer_value = LOW_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (enable && interrupt) begin
                    state_d    = ST_ASSERT;
                    mode_d     = mode_8086;
                    idx_d      = 2'd0;
                    perr_d     = 1'b0;
                    inta_n_d   = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (timer_tc) begin
                    if (idx_q == 2'd1) byte1_d = data_bus_in;
                    if (idx_q == 2'd2) byte2_d = data_bus_in;
`ifdef INTACK_OPCODE_CHECK_EN
                    if (idx_q == 2'd0 && !mode_q && data_bus_in != CALL_OPCODE)
                        perr_d = 1'b1;
`endif
                    inta_n_d    = 1'b1;
                    state_d     = ST_RELEASE;
                    timer_load  = 1'b1;
                    timer_value = HIGH_LOAD;
                end
            end
            ST_RELEASE: begin
                if (timer_tc) begin
                    if (perr_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == last_pulse(mode_q)) begin
                        state_d  = ST_HOLD;
                        valid_d  = 1'b1;
                        vector_d = byte1_q;
                        ca_d     = mode_q ? 16'h0000 : {byte2_q, byte1_q};
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        state_d    = ST_ASSERT;
                        inta_n_d   = 1'b0;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (vector_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            inta_n_q <= 1'b1;
            mode_q   <= 1'b0;
            idx_q    <= 2'd0;
            byte1_q  <= 8'h00;
            byte2_q  <= 8'h00;
            valid_q  <= 1'b0;
            vector_q <= 8'h00;
            ca_q     <= 16'h0000;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            inta_n_q <= inta_n_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            byte1_q  <= byte1_d;
            byte2_q  <= byte2_d;
            valid_q  <= valid_d;
            vector_q <= vector_d;
            ca_q     <= ca_d;
            perr_q   <= perr_d;
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign busy                    = (state_q != ST_IDLE);
    assign vector_valid            = valid_q;
    assign vector                  = vector_q;
    assign call_address            = ca_q;
`ifdef INTACK_OPCODE_CHECK_EN
    assign protocol_error          = perr_q;
`else
    assign protocol_error          = 1'b0;
`endif

endmodule

// File: tb/tb_intack_master.sv
// Scoreboard bench for intack_master: pulse shape, latency, captured vector, reset, hold behaviour.
module tb_intack_master;

    localparam int L = 4;
    localparam int H = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0;
    logic        enable = 1'b0;
    logic        mode_8086 = 1'b0;
    logic [7:0]  data_bus_in = 8'h00;
    logic        vector_ready = 1'b0;
    logic        interrupt_acknowledge_n;
    logic        busy;
    logic        vector_valid;
    logic [7:0]  vector;
    logic [15:0] call_address;
    logic        protocol_error;

    intack_master #(.INTA_LOW_CYCLES(L), .INTA_HIGH_CYCLES(H)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt               (interrupt),
        .enable                  (enable),
        .mode_8086               (mode_8086),
        .data_bus_in             (data_bus_in),
        .vector_ready            (vector_ready),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .busy                    (busy),
        .vector_valid            (vector_valid),
        .vector                  (vector),
        .call_address            (call_address),
        .protocol_error          (protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  vec;
        logic [15:0] ca;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // controller model: drives the next table byte at each INTA falling edge
    logic [7:0] bus_tbl [3];
    int         pulse_cnt = 0;

    always @(negedge interrupt_acknowledge_n) begin
        if (pulse_cnt < 3) data_bus_in = bus_tbl[pulse_cnt];
        else               data_bus_in = 8'hEE;
        pulse_cnt++;
    end

    task automatic run_seq(input string nm, input logic mode,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int exp_pulses, input logic exp_valid, input logic exp_err,
                           input logic drop_mid, input logic chain);
        int   t0, lows, falls, lat;
        logic prev_n, started, done, stable;
        exp_t e, got;

        @(negedge clock);
        bus_tbl[0] = b0;
        bus_tbl[1] = b1;
        bus_tbl[2] = b2;
        pulse_cnt  = 0;
        mode_8086  = mode;
        interrupt  = 1'b1;
        enable     = 1'b1;
        vector_ready = 1'b1;
        if (exp_valid) begin
            e.vec = b1;
            e.ca  = mode ? 16'h0000 : {b2, b1};
            sb_q.push_back(e);
        end

        started = 1'b0; done = 1'b0; prev_n = 1'b1;
        t0 = 0; lows = 0; falls = 0; lat = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clock); #1;
            if (!started && busy) begin
                started = 1'b1;
                t0 = cyc;
                chk({nm, " perr_clear_at_start"}, 32'(protocol_error), 32'd0);
            end
            if (started) begin
                if (!interrupt_acknowledge_n) lows++;
                if (prev_n && !interrupt_acknowledge_n) falls++;
                if (!prev_n && interrupt_acknowledge_n) vector_ready = 1'b0;
                if (drop_mid && falls == 1 && interrupt_acknowledge_n) begin
                    interrupt = 1'b0;
                    enable    = 1'b0;
                    mode_8086 = ~mode;
                end
                prev_n = interrupt_acknowledge_n;
                if (vector_valid) begin
                    lat  = cyc - t0;
                    done = 1'b1;
                end else if (!busy) begin
                    done = 1'b1;
                end
            end
        end
        if (!exp_valid) begin
            interrupt = 1'b0;
            enable    = 1'b0;
        end

        if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
        chk({nm, " pulses"}, 32'(falls), 32'(exp_pulses));
        chk({nm, " low_clocks"}, 32'(lows), 32'(exp_pulses * L));

        if (exp_valid) begin
            chk({nm, " latency"}, 32'(lat), 32'(exp_pulses * (L + H)));
            if (sb_q.size() == 0) begin
                chk({nm, " sb_empty"}, 32'd0, 32'd1);
            end else begin
                got = sb_q.pop_front();
                chk({nm, " vector"}, 32'(vector), 32'(got.vec));
                chk({nm, " call_address"}, 32'(call_address), 32'(got.ca));
                stable = 1'b1;
                repeat (10) begin
                    @(posedge clock); #1;
                    if (!(vector_valid && busy && vector == got.vec && call_address == got.ca))
                        stable = 1'b0;
                end
                chk({nm, " hold_stable"}, 32'(stable), 32'd1);
                vector_ready = 1'b1;
                @(posedge clock); #1;
                vector_ready = 1'b0;
                chk({nm, " ready_clears_valid"}, 32'(vector_valid), 32'd0);
                chk({nm, " ready_to_idle"}, 32'(busy), 32'd0);
                chk({nm, " vector_retained"}, 32'(vector), 32'(got.vec));
                if (chain) begin
                    @(posedge clock); #1;
                    chk({nm, " restart_after_idle"}, 32'(busy), 32'd1);
                end else begin
                    interrupt = 1'b0;
                    enable    = 1'b0;
                end
            end
            chk({nm, " perr"}, 32'(protocol_error), 32'd0);
        end else begin
            chk({nm, " perr"}, 32'(protocol_error), 32'(exp_err));
            chk({nm, " no_valid"}, 32'(vector_valid), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst inta_n", 32'(interrupt_acknowledge_n), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(vector_valid), 32'd0);
        chk("rst vector", 32'(vector), 32'd0);
        chk("rst call_address", 32'(call_address), 32'd0);
        chk("rst perr", 32'(protocol_error), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_seq("x86", 1'b1, 8'hFF, 8'h48, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_seq("mcs80", 1'b0, 8'hCD, 8'h20, 8'h03, 3, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef INTACK_OPCODE_CHECK_EN
        run_seq("opcode_bad", 1'b0, 8'h00, 8'h20, 8'h03, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("opcode_bad perr_sticky", 32'(protocol_error), 32'd1);
`else
        run_seq("opcode_bad", 1'b0, 8'h00, 8'h20, 8'h03, 3, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        run_seq("mcs80_drop", 1'b0, 8'hCD, 8'h11, 8'h22, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        run_seq("x86_chain", 1'b1, 8'hAA, 8'h5A, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b1);

        // restarted sequence is now in its first ASSERT clock; reset in the second
        @(posedge clock); #2;
        chk("mid inta_low", 32'(interrupt_acknowledge_n), 32'd0);
        reset = 1'b1;
        #1;
        chk("async inta_n", 32'(interrupt_acknowledge_n), 32'd1);
        chk("async busy", 32'(busy), 32'd0);
        chk("async valid", 32'(vector_valid), 32'd0);
        chk("async vector", 32'(vector), 32'd0);
        chk("async call_address", 32'(call_address), 32'd0);
        chk("async perr", 32'(protocol_error), 32'd0);
        interrupt = 1'b0;
        enable    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("post_reset idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intack_master.md
INTACK_MASTER -- requirements
Module: intack_master

Interface
REQ-001 Parameter INTA_LOW_CYCLES, default 4, SHALL set the INTA low-phase length in clocks; legal range is 1 or more.
REQ-002 Parameter INTA_HIGH_CYCLES, default 2, SHALL set the INTA high gap between pulses in clocks; legal range is 1 or more.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports are clock and reset.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 interrupt  in  1  INTR from the interrupt controller.
REQ-007 enable  in  1  when 1, new acknowledge sequences are permitted.
REQ-008 mode_8086  in  1  selects the acknowledge format: 1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses).
REQ-009 data_bus_in  in  8  data bus driven by the controller during INTA.
REQ-010 vector_ready  in  1  consumer accepts the vector.
REQ-011 interrupt_acknowledge_n  out  1  registered INTA strobe, active low.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 vector_valid  out  1  captured result available.
REQ-014 vector  out  8  8086 vector byte, or MCS-80 low call-address byte.
REQ-015 call_address  out  16  MCS-80 {high byte, low byte}; 0 in 8086 mode.
REQ-016 protocol_error  out  1  MCS-80 opcode mismatch flag (see Configuration).

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ASSERT, RELEASE and HOLD.
REQ-018 IDLE->ASSERT SHALL occur at an edge where enable=1 and interrupt=1; that same edge SHALL latch mode_8086, clear pulse_index, clear protocol_error and drive interrupt_acknowledge_n=0.
REQ-019 ASSERT SHALL last INTA_LOW_CYCLES clocks; the final ASSERT edge SHALL capture data_bus_in into byte[pulse_index] and drive interrupt_acknowledge_n=1.
REQ-020 RELEASE SHALL last INTA_HIGH_CYCLES clocks.
REQ-021 On leaving RELEASE, the FSM SHALL go to HOLD if pulse_index equals the last pulse (1 for 8086, 2 for MCS-80); otherwise it SHALL increment pulse_index and return to ASSERT.
REQ-022 Latency: vector_valid SHALL rise exactly N*(INTA_LOW_CYCLES+INTA_HIGH_CYCLES) clocks after the start edge, where N is the pulse count (8086 defaults: 12; MCS-80 defaults: 18).
REQ-023 In 8086 mode, vector SHALL be byte[1]; byte[0] SHALL be discarded; call_address SHALL be 0.
REQ-024 In MCS-80 mode, vector SHALL be byte[1] and call_address SHALL be {byte[2], byte[1]}.
REQ-025 In HOLD, vector_valid=1 SHALL be held with vector and call_address stable until an edge with vector_ready=1; that edge SHALL clear vector_valid and go to IDLE.
REQ-026 vector and call_address SHALL retain their values after HOLD is left, until the next capture.
REQ-027 After HOLD the block SHALL spend at least one cycle in IDLE before restarting, even if interrupt remains 1.
REQ-028 Deassertion of interrupt or enable mid-sequence SHALL NOT abort the sequence.
REQ-029 mode_8086 changes mid-sequence SHALL be ignored.
REQ-030 vector_ready while not in HOLD SHALL be ignored.

Reset
REQ-031 Reset SHALL force, asynchronously: state=IDLE, interrupt_acknowledge_n=1, busy=0, vector_valid=0, vector=0, call_address=0, protocol_error=0, pulse_index=0, phase counter=0.
REQ-032 Reset asserted mid-ASSERT SHALL release interrupt_acknowledge_n immediately, without waiting for a clock edge.

Configuration
REQ-033 With INTACK_OPCODE_CHECK_EN defined, in MCS-80 mode the block SHALL compare byte[0] against 8'hCD; a mismatch SHALL set protocol_error, complete the current pulse and RELEASE, then return to IDLE without asserting vector_valid.
REQ-034 protocol_error SHALL remain set until the next start edge or reset.
REQ-035 Without INTACK_OPCODE_CHECK_EN, byte[0] SHALL be ignored and protocol_error SHALL be tied to 0.

Structure
REQ-036 KF8259_Common_Package SHALL hold the state encoding typedef, the CALL_OPCODE constant 8'hCD, and the pulse-count constants 2 and 3.
REQ-037 One sub-module, intack_phase_timer, SHALL implement the loadable phase down-counter and its terminal-count flag; the FSM and capture logic SHALL remain in intack_master.

Verification
REQ-038 8086 mode, defaults: interrupt=1, bus 8'hFF on pulse 1 and 8'h48 on pulse 2 -> exactly 2 INTA pulses of 4 low / 2 high clocks, vector_valid at +12 clocks, vector=8'h48, call_address=0.
REQ-039 MCS-80 mode: bus CD, 20, 03 on successive pulses -> 3 pulses, vector_valid at +18 clocks, vector=8'h20, call_address=16'h0320.
REQ-040 vector_ready held 0 for 10 cycles -> outputs remain stable; vector_ready=1 -> IDLE next edge; with interrupt still 1, the next sequence starts no earlier than one IDLE cycle later.
REQ-041 Reset pulsed in the 2nd ASSERT cycle -> interrupt_acknowledge_n=1 asynchronously and all outputs at reset values.
REQ-042 With INTACK_OPCODE_CHECK_EN, MCS-80 first byte 8'h00 -> protocol_error=1, a single pulse, no vector_valid; without the macro, the same stimulus yields the normal 3-pulse result.
REQ-043 interrupt dropped after pulse 1 -> the sequence still completes with the full pulse count.
